// File: rtl/float_divider_seq.sv
// float_divider_seq
// Iterative IEEE-754 single-precision divider computing A / B. One quotient
// bit per clock by unsigned restoring division of the hidden-bit mantissas,
// followed by a single normalisation cycle. The result is truncated.
// Operands with exponent field 0 are zero; exponent 255 is an ordinary value.
//
// Handshake: start is accepted only in IDLE (A and B sampled on that edge).
// busy is high from the cycle after acceptance until done. done is a one-cycle
// pulse with result valid in the same cycle. result holds until the next done.
// busy and done are never high together.
//
// Ports:
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   request, sampled in IDLE only
//   A       in  32   dividend
//   B       in  32   divisor
//   busy    out  1   operation in progress
//   done    out  1   result valid pulse
//   result  out 32   quotient
module float_divider_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_t;

  // state is the FSM observation point for bound checkers
  state_t      state;
  state_t      state_nxt;

  logic [4:0]  counter;
  logic [24:0] rem;
  logic [24:0] quo;
  logic [23:0] mb;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic        sign;
  logic        special;
  logic [31:0] special_res;

  logic        a_zero;
  logic        b_zero;
  logic [24:0] mb_ext;
  logic [24:0] diff;
  logic        ge;
  logic signed [9:0] exp_calc;
  logic [22:0] mant;
  logic [31:0] result_nxt;

  assign a_zero = (A[30:23] == 8'd0);
  assign b_zero = (B[30:23] == 8'd0);
  assign mb_ext = {1'b0, mb};
  assign diff   = rem - mb_ext;
  assign ge     = (rem >= mb_ext);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (a_zero || b_zero) ? NORM : DIV;
      DIV:  if (counter == 5'd0) state_nxt = NORM;
      NORM: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: busy and the normalised result computed from the quotient
  always_comb begin
    busy = (state != IDLE);
    // Quotient lies in (0.5, 2): bit 24 set means >= 1.0
    mant = quo[24] ? quo[23:1] : quo[22:0];
    exp_calc = $signed({2'b00, ea}) - $signed({2'b00, eb})
             + (quo[24] ? 10'sd127 : 10'sd126);
    if (special)
      result_nxt = special_res;
    else if (exp_calc >= 10'sd255)
      result_nxt = {sign, 8'hFF, 23'h0};
    else if (exp_calc <= 10'sd0)
      result_nxt = {sign, 31'h0};
    else
      result_nxt = {sign, exp_calc[7:0], mant};
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter     <= 5'd0;
      rem         <= 25'd0;
      quo         <= 25'd0;
      mb          <= 24'd0;
      ea          <= 8'd0;
      eb          <= 8'd0;
      sign        <= 1'b0;
      special     <= 1'b0;
      special_res <= 32'h0;
      done        <= 1'b0;
      result      <= 32'h0;
    end else begin
      done <= (state == NORM);
      if (state == NORM) result <= result_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            rem     <= {2'b01, A[22:0]};
            mb      <= {1'b1, B[22:0]};
            ea      <= A[30:23];
            eb      <= B[30:23];
            sign    <= A[31] ^ B[31];
            quo     <= 25'd0;
            counter <= 5'd24;
            special <= a_zero || b_zero;
            if (a_zero && b_zero)
              special_res <= 32'h7FC00000;
            else if (b_zero)
              special_res <= {A[31] ^ B[31], 8'hFF, 23'h0};
            else
              special_res <= {A[31] ^ B[31], 31'h0};
          end
        end
        DIV: begin
          // Remainder stays below 2*Mb, so the shifted value fits in 25 bits
          rem <= ge ? {diff[23:0], 1'b0} : {rem[23:0], 1'b0};
          quo <= {quo[23:0], ge};
          if (counter != 5'd0) counter <= counter - 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_divider_seq.sv
module tb_float_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  float_divider_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // busy and done must never overlap
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (busy && done) begin
        failures++;
        $display("FAIL busy_done_overlap: busy=%b done=%b, required not both high", busy, done);
      end
    end
  end

  // Reference quotient from the arithmetic rules, using wide integer division
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, q;
    int ea_i, eb_i, e;
    logic [22:0] m;
    logic s;
    s = a[31] ^ b[31];
    ea_i = a[30:23];
    eb_i = b[30:23];
    if (ea_i == 0 && eb_i == 0) return 32'h7FC00000;
    if (eb_i == 0) return {s, 8'hFF, 23'h0};
    if (ea_i == 0) return {s, 31'h0};
    ma = 0; ma[23:0] = {1'b1, a[22:0]};
    mb = 0; mb[23:0] = {1'b1, b[22:0]};
    q = (ma << 24) / mb;
    e = ea_i - eb_i + 127;
    if (q >= 64'd16777216) m = q[23:1];
    else begin
      m = q[22:0];
      e = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], m};
  endfunction

  // Driver: issue one operation, return the result and cycles from accept to done
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++;
    if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h, required 00000000", result); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exact();
    @(negedge clk);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL exact_busy_c0: got %b, required 1", busy); end
    for (int c = 1; c <= 27; c++) begin
      @(posedge clk); #1;
      if (c <= 25) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          failures++;
          $display("FAIL exact_busy_c%0d: busy=%b done=%b, required busy=1 done=0", c, busy, done);
        end
      end else if (c == 26) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL exact_done_c26: busy=%b done=%b, required busy=0 done=1", busy, done);
        end
        checks++;
        if (result !== 32'h40400000) begin
          failures++;
          $display("FAIL exact_result: got %h, required 40400000", result);
        end
      end else begin
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL exact_done_c27: got %b, required 0", done); end
      end
    end
  endtask

  task automatic test_truncation();
    logic [31:0] r;
    int lat;
    do_op(32'h3F800000, 32'h40400000, r, lat);
    checks++;
    if (r !== 32'h3EAAAAAA) begin failures++; $display("FAIL trunc_result: got %h, required 3EAAAAAA", r); end
    checks++;
    if (lat !== 26) begin failures++; $display("FAIL trunc_latency: got %0d, required 26", lat); end
  endtask

  task automatic test_sign_ignore();
    logic [31:0] r;
    int lat;
    int done_c;
    @(negedge clk);
    A = 32'hBF800000; B = 32'h3F000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_c = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 && done_c < 0) begin
        done_c = c;
        r = result;
      end
      // A competing request while busy must be ignored
      if (c == 4) begin A = 32'h40000000; B = 32'h3F800000; start = 1'b1; end
      if (c == 10) start = 1'b0;
    end
    checks++;
    if (done_c !== 26) begin failures++; $display("FAIL sign_done_cycle: got %0d, required 26", done_c); end
    checks++;
    if (r !== 32'hC0000000) begin failures++; $display("FAIL sign_result: got %h, required C0000000", r); end
    do_op(32'h3F800000, 32'h3F800000, r, lat);
    checks++;
    if (r !== 32'h3F800000) begin failures++; $display("FAIL one_result: got %h, required 3F800000", r); end
    checks++;
    if (lat !== 26) begin failures++; $display("FAIL one_latency: got %0d, required 26", lat); end
  endtask

  task automatic test_specials_range();
    logic [31:0] ta[5], tbv[5], te[5];
    int tl[5];
    logic [31:0] r;
    int lat;
    ta[0] = 32'h3F800000; tbv[0] = 32'h00000000; te[0] = 32'h7F800000; tl[0] = 1;
    ta[1] = 32'h80000000; tbv[1] = 32'h40000000; te[1] = 32'h80000000; tl[1] = 1;
    ta[2] = 32'h00000000; tbv[2] = 32'h00000000; te[2] = 32'h7FC00000; tl[2] = 1;
    ta[3] = 32'h7F000000; tbv[3] = 32'h00800000; te[3] = 32'h7F800000; tl[3] = 26;
    ta[4] = 32'h00800000; tbv[4] = 32'h7F000000; te[4] = 32'h00000000; tl[4] = 26;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tbv[i], r, lat);
      checks++;
      if (r !== te[i]) begin
        failures++;
        $display("FAIL special_result[%0d]: %h/%h got %h, required %h", i, ta[i], tbv[i], r, te[i]);
      end
      checks++;
      if (lat !== tl[i]) begin
        failures++;
        $display("FAIL special_latency[%0d]: got %0d, required %0d", i, lat, tl[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int lat;
    bit saw_done;
    // Leave a nonzero result behind so the clear is observable
    do_op(32'h40C00000, 32'h40000000, r, lat);
    @(negedge clk);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL midreset_clear: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin failures++; $display("FAIL midreset_no_done: got done pulse, required none"); end
    do_op(32'h40C00000, 32'h40000000, r, lat);
    checks++;
    if (r !== 32'h40400000 || lat !== 26) begin
      failures++;
      $display("FAIL midreset_rerun: result=%h lat=%0d, required 40400000 26", r, lat);
    end
  endtask

  task automatic test_held_start();
    int dq[$];
    bit drained;
    @(negedge clk);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 56; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dq.push_back(c);
    end
    start = 1'b0;
    checks++;
    if (dq.size() < 2) begin
      failures++;
      $display("FAIL held_done_count: got %0d pulses, required 2", dq.size());
    end else if (dq[0] != 26 || dq[1] != 53) begin
      failures++;
      $display("FAIL held_done_cycles: got %0d,%0d, required 26,53", dq[0], dq[1]);
    end
    drained = 1'b0;
    for (int c = 0; c < 40 && !drained; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) drained = 1'b1;
    end
    checks++;
    if (!drained) begin failures++; $display("FAIL held_drain: got no third done, required one"); end
  endtask

  task automatic test_back_to_back_random();
    logic [31:0] a, b, r, e;
    int lat, exp_lat;
    for (int i = 0; i < 40; i++) begin
      a[31] = 1'($urandom_range(0, 1));
      a[30:23] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      a[22:0] = 23'($urandom);
      b[31] = 1'($urandom_range(0, 1));
      b[30:23] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      b[22:0] = 23'($urandom);
      exp_q.push_back(ref_div(a, b));
      exp_lat = (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? 1 : 26;
      do_op(a, b, r, lat);
      e = exp_q.pop_front();
      checks++;
      if (r !== e) begin
        failures++;
        $display("FAIL random_result[%0d]: %h/%h got %h, required %h", i, a, b, r, e);
      end
      checks++;
      if (lat !== exp_lat) begin
        failures++;
        $display("FAIL random_latency[%0d]: got %0d, required %0d", i, lat, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_truncation();
    test_sign_ignore();
    test_specials_range();
    test_reset_mid();
    test_held_start();
    test_back_to_back_random();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
